// File: rtl/integral_sched.sv
// Frame scheduler for the 4-lane integral datapath: walks column pairs (k, N_COLS-k),
// aligns valid/indices to read data and tracks credits and in-flight beats.
// Optional stall counter output enabled by INTEG_SCHED_STALL_CNT_EN.
module integral_sched #(
  parameter int N_COLS  = 2048,
  parameter int IDX_W   = 11,
  parameter int RD_LAT  = 2,
  parameter int CREDITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             src_rdy,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_addr_col1,
  output logic [IDX_W-1:0] rd_addr_col2,
  output logic             dp_valid,
  output logic [IDX_W-1:0] dp_index_col_1,
  output logic [IDX_W-1:0] dp_index_col_2,
  input  logic             dp_ready,
  input  logic             credit_ret,
  output logic             err_credit
`ifdef INTEG_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // state | meaning
  // IDLE  | waiting for start
  // ISSUE | issuing beats k = 0..N_COLS/2 as src_rdy and credits allow
  // DRAIN | waiting for read pipe and in-flight beats to empty
  // DONE  | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int INF_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N_COLS / 2);
  localparam logic [IDX_W-1:0] NC_MOD   = IDX_W'(N_COLS);
  localparam logic [7:0]       CRED_MAX = 8'(CREDITS);

  state_t             state;
  logic [IDX_W-1:0]   k;
  logic [7:0]         credits;
  logic [INF_W-1:0]   inflight;
  logic [INF_W-1:0]   inflight_nxt;
  logic [IDX_W-1:0]   col1;
  logic [IDX_W-1:0]   col2;
  logic [IDX_W-1:0]   addr1_q;
  logic [IDX_W-1:0]   addr2_q;
  logic [RD_LAT-1:0]  pipe_v;
  logic [IDX_W-1:0]   pipe_c1 [RD_LAT];
  logic [IDX_W-1:0]   pipe_c2 [RD_LAT];
  logic               pipe_empty;

  // Column 2 wraps modulo 2^IDX_W; k=0 pairs with itself.
  assign col1 = k;
  assign col2 = (k == '0) ? '0 : NC_MOD - k;

  assign rd_en        = (state == ISSUE) && src_rdy && (credits != 8'd0);
  assign rd_addr_col1 = rd_en ? col1 : addr1_q;
  assign rd_addr_col2 = rd_en ? col2 : addr2_q;
  assign pipe_empty   = ~|pipe_v;

  assign dp_valid       = pipe_v[RD_LAT-1];
  assign dp_index_col_1 = pipe_c1[RD_LAT-1];
  assign dp_index_col_2 = pipe_c2[RD_LAT-1];

  always_comb begin
    inflight_nxt = inflight;
    if (rd_en && !dp_ready)
      inflight_nxt = inflight + INF_W'(1);
    else if (!rd_en && dp_ready && inflight != '0)
      inflight_nxt = inflight - INF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
    end else begin
      if (rd_en) begin
        addr1_q <= col1;
        addr2_q <= col2;
      end
      case (state)
        IDLE: if (start) begin
          state <= ISSUE;
          k     <= '0;
          busy  <= 1'b1;
        end
        ISSUE: if (rd_en) begin
          k <= k + IDX_W'(1);
          if (k == K_LAST) state <= DRAIN;
        end
        // Look ahead at the in-flight count so done follows the last dp_ready directly.
        DRAIN: if (inflight_nxt == '0 && pipe_empty) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits    <= CRED_MAX;
      err_credit <= 1'b0;
      inflight   <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (rd_en && !credit_ret)
        credits <= credits - 8'd1;
      else if (!rd_en && credit_ret) begin
        if (credits == CRED_MAX) err_credit <= 1'b1;
        else                     credits    <= credits + 8'd1;
      end
    end
  end

  // Indices enter the pipe masked so they read 0 whenever dp_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_c1[i] <= '0;
        pipe_c2[i] <= '0;
      end
    end else begin
      pipe_v[0]  <= rd_en;
      pipe_c1[0] <= rd_en ? col1 : '0;
      pipe_c2[0] <= rd_en ? col2 : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_c1[i] <= pipe_c1[i-1];
        pipe_c2[i] <= pipe_c2[i-1];
      end
    end
  end

`ifdef INTEG_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (state == ISSUE && !rd_en && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_integral_sched.sv
// Directed bench for integral_sched: instance a (CREDITS=8) and instance b (CREDITS=2),
// both N_COLS=8, RD_LAT=2; dp_ready comes from a 4-cycle datapath delay model.
module tb_integral_sched;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, src_rdy_a, dp_ready_a, credit_ret_a;
  logic       busy_a, done_a, rd_en_a, dp_valid_a, err_a;
  logic [3:0] a1_a, a2_a, i1_a, i2_a;
  logic       start_b, src_rdy_b, dp_ready_b, credit_ret_b;
  logic       busy_b, done_b, rd_en_b, dp_valid_b, err_b;
  logic [3:0] a1_b, a2_b, i1_b, i2_b;
`ifdef INTEG_SCHED_STALL_CNT_EN
  logic [15:0] stall_a, stall_b;
`endif

  integral_sched #(.N_COLS(N), .IDX_W(4), .RD_LAT(2), .CREDITS(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .src_rdy(src_rdy_a), .rd_en(rd_en_a), .rd_addr_col1(a1_a), .rd_addr_col2(a2_a),
    .dp_valid(dp_valid_a), .dp_index_col_1(i1_a), .dp_index_col_2(i2_a),
    .dp_ready(dp_ready_a), .credit_ret(credit_ret_a), .err_credit(err_a)
`ifdef INTEG_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  integral_sched #(.N_COLS(N), .IDX_W(4), .RD_LAT(2), .CREDITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .src_rdy(src_rdy_b), .rd_en(rd_en_b), .rd_addr_col1(a1_b), .rd_addr_col2(a2_b),
    .dp_valid(dp_valid_b), .dp_index_col_1(i1_b), .dp_index_col_2(i2_b),
    .dp_ready(dp_ready_b), .credit_ret(credit_ret_b), .err_credit(err_b)
`ifdef INTEG_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit tie_a, tie_b;
  bit [3:0] hist_a, hist_b;
  logic lv_a, lv_b;
  int mk [2];
  bit pv [2][2];
  int pc1 [2][2];
  int pc2 [2][2];
  bit e_err [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int id);
    mk[id] = 0;
    for (int j = 0; j < 2; j++) begin
      pv[id][j] = 1'b0; pc1[id][j] = 0; pc2[id][j] = 0;
    end
  endtask

  // Advance one cycle; inputs may then be set, outputs checked #1 later.
  task automatic tick();
    lv_a = dp_valid_a;
    lv_b = dp_valid_b;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
    hist_a = {hist_a[2:0], lv_a};
    hist_b = {hist_b[2:0], lv_b};
    dp_ready_a = hist_a[3];
    dp_ready_b = hist_b[3];
    credit_ret_a = tie_a ? dp_ready_a : 1'b0;
    credit_ret_b = tie_b ? dp_ready_b : 1'b0;
  endtask

  task automatic chk(input int id, input bit e_rd, input bit e_busy, input bit e_done);
    logic o_rd, o_v, o_busy, o_done, o_err;
    logic [3:0] o_a1, o_a2, o_i1, o_i2;
    int x1, x2;
    if (id == 0) begin
      o_rd = rd_en_a; o_v = dp_valid_a; o_busy = busy_a; o_done = done_a; o_err = err_a;
      o_a1 = a1_a; o_a2 = a2_a; o_i1 = i1_a; o_i2 = i2_a;
    end else begin
      o_rd = rd_en_b; o_v = dp_valid_b; o_busy = busy_b; o_done = done_b; o_err = err_b;
      o_a1 = a1_b; o_a2 = a2_b; o_i1 = i1_b; o_i2 = i2_b;
    end
    x1 = mk[id];
    x2 = (mk[id] == 0) ? 0 : N - mk[id];
    check($sformatf("u%0d rd_en", id), o_rd, e_rd);
    if (e_rd) begin
      check($sformatf("u%0d rd_addr_col1", id), o_a1, x1);
      check($sformatf("u%0d rd_addr_col2", id), o_a2, x2);
    end
    check($sformatf("u%0d dp_valid", id), o_v, pv[id][1]);
    check($sformatf("u%0d dp_index_col_1", id), o_i1, pc1[id][1]);
    check($sformatf("u%0d dp_index_col_2", id), o_i2, pc2[id][1]);
    check($sformatf("u%0d busy", id), o_busy, e_busy);
    check($sformatf("u%0d done", id), o_done, e_done);
    check($sformatf("u%0d err_credit", id), o_err, e_err[id]);
    pv[id][1]  = pv[id][0];  pv[id][0]  = e_rd;
    pc1[id][1] = pc1[id][0]; pc1[id][0] = e_rd ? x1 : 0;
    pc2[id][1] = pc2[id][0]; pc2[id][0] = e_rd ? x2 : 0;
    if (e_rd) mk[id]++;
  endtask

  task automatic plain_frame_a(input string tag);
    for (int t = 0; t <= 13; t++) begin
      tick();
      src_rdy_a = 1'b1;
      if (t == 0) begin start_a = 1'b1; model_clear(0); end
      if (t == 3) start_a = 1'b1;
      #1;
      chk(0, t >= 1 && t <= 5, t >= 1 && t <= 11, t == 12);
    end
    $display("[TB] %s frame finished", tag);
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 0; src_rdy_a = 0; dp_ready_a = 0; credit_ret_a = 0;
    start_b = 0; src_rdy_b = 0; dp_ready_b = 0; credit_ret_b = 0;
    tie_a = 1'b1; tie_b = 1'b0; hist_a = '0; hist_b = '0;
    e_err[0] = 1'b0; e_err[1] = 1'b0;
    model_clear(0); model_clear(1);

    // reset state
    tick(); tick();
    #1;
    chk(0, 0, 0, 0);
    chk(1, 0, 0, 0);
    check("reset rd_addr_a", {a1_a, a2_a}, 0);
    check("reset rd_addr_b", {a1_b, a2_b}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    #1;
    chk(0, 0, 0, 0);

    // basic frame (also covers a second start at cycle 3 being ignored)
    plain_frame_a("basic");

    // src_rdy toggling; start in the DONE cycle is ignored
    for (int t = 0; t <= 16; t++) begin
      tick();
      src_rdy_a = (t % 2 == 1);
      if (t == 0) begin start_a = 1'b1; model_clear(0); end
      if (t == 16) start_a = 1'b1;
      #1;
      chk(0, (t % 2 == 1) && t <= 9, t >= 1 && t <= 15, t == 16);
    end

    // start in the IDLE cycle right after DONE is accepted
    for (int t = 0; t <= 13; t++) begin
      tick();
      src_rdy_a = 1'b1;
      if (t == 0) begin start_a = 1'b1; model_clear(0); end
      if (t == 3) start_a = 1'b1;
      #1;
`ifdef INTEG_SCHED_STALL_CNT_EN
      if (t == 0) check("u0 stall_cnt toggle", stall_a, 4);
      if (t == 13) check("u0 stall_cnt no stall", stall_a, 0);
`endif
      chk(0, t >= 1 && t <= 5, t >= 1 && t <= 11, t == 12);
    end

    // reset mid-frame
    for (int t = 0; t <= 3; t++) begin
      tick();
      if (t == 0) begin start_a = 1'b1; model_clear(0); end
      #1;
      chk(0, t >= 1, t >= 1, 0);
    end
    tick();
    rst_n = 1'b0;
    hist_a = '0; dp_ready_a = 1'b0; credit_ret_a = 1'b0;
    #1;
    check("mid rst busy", busy_a, 0);
    check("mid rst done", done_a, 0);
    check("mid rst rd_en", rd_en_a, 0);
    check("mid rst rd_addr", {a1_a, a2_a}, 0);
    check("mid rst dp_valid", dp_valid_a, 0);
    check("mid rst dp_index", {i1_a, i2_a}, 0);
    check("mid rst err_credit", err_a, 0);
    model_clear(0);
    tick(); tick();
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      #1;
      chk(0, 0, 0, 0);
    end
    plain_frame_a("restart");

    // credit starvation on instance b
    src_rdy_b = 1'b1;
    for (int t = 0; t <= 31; t++) begin
      tick();
      if (t == 0) begin start_b = 1'b1; model_clear(1); end
      credit_ret_b = (t >= 20 && t <= 22);
      #1;
      chk(1, t == 1 || t == 2 || (t >= 21 && t <= 23), t >= 1 && t <= 29, t == 30);
`ifdef INTEG_SCHED_STALL_CNT_EN
      if (t == 31) check("u1 stall_cnt starved", stall_b, 18);
`endif
    end

    // return the two outstanding credits, then one too many
    for (int u = 0; u <= 5; u++) begin
      tick();
      credit_ret_b = (u <= 2);
      #1;
      if (u == 3) e_err[1] = 1'b1;
      chk(1, 0, 0, 0);
    end

    // credits saturated at 2: exactly two beats then a stall
    for (int t = 0; t <= 10; t++) begin
      tick();
      if (t == 0) begin start_b = 1'b1; model_clear(1); end
      #1;
`ifdef INTEG_SCHED_STALL_CNT_EN
      if (t == 0) check("u1 stall_cnt hold", stall_b, 18);
      if (t == 10) check("u1 stall_cnt restart", stall_b, 7);
`endif
      chk(1, t == 1 || t == 2, t >= 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/integral_sched.md
Name: integral_sched

Overview:
- Frame-level scheduler for the 4-lane power/magnitude-squared `intergral` datapath.
- On `start`, walks the FFT column pairs of one frame, (k, N_COLS−k), issuing read addresses to the column buffer. It drives the datapath `valid` and index inputs aligned to the returned read data.
- Admission is credit-based, because the datapath cannot stall. In-flight beats are tracked until the datapath's `ready` flag drains them, then `done` pulses.

Parameters:
- N_COLS, 2048, columns per frame; power of 2, ≥8; must satisfy N_COLS ≤ 2^IDX_W.
- IDX_W, 11, width of column indices.
- RD_LAT, 2, column-buffer read latency in cycles; ≥1.
- CREDITS, 8, downstream buffer slots; 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- src_rdy  in  1  column buffer holds a complete frame
- rd_en  out  1  column-buffer read strobe
- rd_addr_col1  out  IDX_W  read address, column 1
- rd_addr_col2  out  IDX_W  read address, column 2
- dp_valid  out  1  datapath `valid`
- dp_index_col_1  out  IDX_W  datapath `index_col_1`
- dp_index_col_2  out  IDX_W  datapath `index_col_2`
- dp_ready  in  1  datapath output flag (4 cycles after `dp_valid`)
- credit_ret  in  1  downstream released one slot
- err_credit  out  1  sticky credit-overflow error

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - The credit counter loads CREDITS; the beat and in-flight counters are 0.
  - Reset mid-frame abandons the frame; no `done` is produced.
- Beat sequence, per frame:
  - k = 0..N_COLS/2, giving N_COLS/2+1 beats.
  - Column 1 = k.
  - Column 2 = 0 when k=0, otherwise N_COLS−k computed modulo 2^IDX_W.
  - k=N_COLS/2 issues (N/2, N/2).
- States:
  - IDLE: `busy`=0. `start`=1 → ISSUE, with k cleared.
  - ISSUE: `busy`=1. Issues a beat when `src_rdy` && credits>0. After the beat with k=N_COLS/2 → DRAIN.
  - DRAIN: `busy`=1. Waits for in-flight=0 and the read pipe empty, then → DONE.
  - DONE: `done`=1 for exactly one cycle, then → IDLE. `busy`=0 in DONE.
- `start` while not in IDLE is ignored. A frame with `start` at cycle t can issue its first beat at t+1.
- Issue cycle:
  - `rd_en`=1, with the addresses combinational from k; k increments.
  - Stall cycles (src_rdy=0 or credits=0) hold `rd_en`=0 and k unchanged; the addresses hold their last value.
- Read alignment:
  - `dp_valid` and the dp indices are `rd_en` and the addresses registered through an RD_LAT-deep shift pipe.
  - `dp_valid` therefore rises exactly RD_LAT cycles after `rd_en`. The dp indices are 0 whenever `dp_valid`=0.
- Credits:
  - −1 on issue, +1 on `credit_ret`; both in the same cycle leaves the count unchanged.
  - `credit_ret` with the count already at CREDITS and no issue saturates the count and sets `err_credit`.
  - `err_credit` clears only on reset.
- In-flight counter:
  - +1 on issue, −1 on `dp_ready`; both in the same cycle leaves it unchanged.
  - `dp_ready` at 0 is ignored; the counter does not wrap.
- Minimum frame: N_COLS/2+1 issue cycles + RD_LAT + 4 + 1 (DONE).
- Back-to-back frames: `start` in the DONE cycle is ignored; `start` in the following IDLE cycle is accepted.

Optional Feature:
- Macro: INTEG_SCHED_STALL_CNT_EN.
- Defined:
  - Adds output `stall_cnt` [15:0], which counts ISSUE-state cycles with `rd_en`=0.
  - Clears on accepted `start` and saturates at 16'hFFFF. Reset value 0; holds after the frame.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- N_COLS=8, RD_LAT=2, src_rdy=1, credit_ret tied to dp_ready, start pulse at cycle 0:
  - `rd_en` at cycles 1–5 with address pairs (0,0),(1,7),(2,6),(3,5),(4,4).
  - `dp_valid` at 3–7 with the same indices; `dp_ready` at 7–11.
  - `done` at 12 only; `busy` 1 at cycles 1–11.
- CREDITS=2, credit_ret held 0 until cycle 20:
  - Exactly 2 `rd_en` beats, then a stall.
  - After 3 `credit_ret` pulses from cycle 20, issue resumes and the beat order is unchanged.
  - With STALL_CNT_EN, `stall_cnt` equals the stalled ISSUE cycles.
- src_rdy toggling 1,0,1,0: `rd_en` only on src_rdy=1 cycles; k advances by 1 per issue; no index skipped or repeated.
- Second `start` at cycle 3 of a frame: ignored, sequence unaffected, exactly one `done`.
- rst_n pulsed low at cycle 4 mid-frame: all outputs 0 immediately; no `done`. A new `start` then restarts at k=0 with credits=CREDITS.
- `credit_ret` pulse in IDLE with credits=CREDITS: `err_credit`=1 and stays 1; credits stay at CREDITS.
